// File: rtl/instr_fifo_if.sv
// instr_fifo_if: fetch -> queue -> decode handshake bundle.
//   master : the fetch/decode side (drives pushes, flush, dec_ready)
//   slave  : the queue itself (drives head entry, full flag, occupancy)
interface instr_fifo_if #(
   parameter int DEPTH   = 8,
   parameter int INSTR_W = 32,
   parameter int PC_W    = 32
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic               fetch_valid;
   logic [INSTR_W-1:0] fetch_instr;
   logic [PC_W-1:0]    fetch_pc;
   logic               flush;
   logic               I_FIFO_Full;
   logic               dec_valid;
   logic [INSTR_W-1:0] dec_instr;
   logic [PC_W-1:0]    dec_pc;
   logic               dec_ready;
   logic [CW-1:0]      count;

   modport master (
      output fetch_valid, fetch_instr, fetch_pc, flush, dec_ready,
      input  I_FIFO_Full, dec_valid, dec_instr, dec_pc, count
   );

   modport slave (
      input  fetch_valid, fetch_instr, fetch_pc, flush, dec_ready,
      output I_FIFO_Full, dec_valid, dec_instr, dec_pc, count
   );
endinterface

// File: rtl/instr_fifo.sv
// instr_fifo: instruction/PC queue between fetch and decode.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : instr_fifo_if.slave
//                fetch_valid/fetch_instr/fetch_pc  push side
//                dec_valid/dec_instr/dec_pc/dec_ready  pop side (valid/ready)
//                flush        empties the queue, beats any push/pop
//                I_FIFO_Full  DEPTH entries held (feeds fetch stall)
//                count        occupancy 0..DEPTH
// All outputs are functions of registered pointers/storage only.
module instr_fifo #(
   parameter int DEPTH   = 8,
   parameter int INSTR_W = 32,
   parameter int PC_W    = 32
) (
   input logic         clk,
   input logic         rst_n,
   instr_fifo_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
   localparam logic [PW-1:0] ONE_C   = PW'(1);

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    pc;
   } entry_t;

   // Storage is not reset; only the pointers define what is valid.
   entry_t        mem_q [DEPTH];

   // MSB of each pointer is a wrap bit: equal pointers = empty,
   // equal low bits with differing MSB = full.
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] count_w;
   logic          empty_w, full_w;
   logic          push_w, pop_w;
   entry_t        head_w, wr_entry_w;

   assign count_w = wr_ptr_q - rd_ptr_q;
   assign empty_w = (wr_ptr_q == rd_ptr_q);
   assign full_w  = (count_w == DEPTH_C);

   // Full comes from registered state only, so a pop in the same cycle
   // cannot open room for a push (no dec_ready -> accept path).
   assign push_w = bus.fetch_valid && !full_w && !bus.flush;
   assign pop_w  = !empty_w && bus.dec_ready && !bus.flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (bus.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push_w) wr_ptr_d = wr_ptr_q + ONE_C;
         if (pop_w)  rd_ptr_d = rd_ptr_q + ONE_C;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   assign wr_entry_w.instr = bus.fetch_instr;
   assign wr_entry_w.pc    = bus.fetch_pc;

   always_ff @(posedge clk) begin
      if (push_w) mem_q[wr_ptr_q[AW-1:0]] <= wr_entry_w;
   end

   // No bypass: a pushed entry reaches the head one cycle after its edge.
   assign head_w = mem_q[rd_ptr_q[AW-1:0]];

   assign bus.dec_valid   = !empty_w;
   assign bus.dec_instr   = empty_w ? '0 : head_w.instr;
   assign bus.dec_pc      = empty_w ? '0 : head_w.pc;
   assign bus.count       = count_w;
   assign bus.I_FIFO_Full = full_w;
endmodule

// File: tb/tb_instr_fifo.sv
module tb_instr_fifo;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   instr_fifo_if #(.DEPTH(8), .INSTR_W(32), .PC_W(32)) bus ();

   instr_fifo #(.DEPTH(8), .INSTR_W(32), .PC_W(32)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        fl;
      logic        fv;
      logic [31:0] pc;
      logic        dr;
      logic [3:0]  cnt;
      logic        full;
      logic        dv;
      logic [31:0] epc;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [31:0] mk_instr(input logic [31:0] pc);
      return {pc[15:0], 16'h0013};
   endfunction

   task automatic add(input logic fl, input logic fv, input logic [31:0] pc, input logic dr,
                      input int cnt, input logic full, input logic dv, input logic [31:0] epc);
      vec_t v;
      v.fl = fl; v.fv = fv; v.pc = pc; v.dr = dr;
      v.cnt = 4'(cnt); v.full = full; v.dv = dv; v.epc = epc;
      tbl.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic fl, input logic fv, input logic [31:0] pc, input logic dr);
      bus.flush       = fl;
      bus.fetch_valid = fv;
      bus.fetch_pc    = pc;
      bus.fetch_instr = (pc == 32'h300) ? 32'h0000_0013 : mk_instr(pc);
      bus.dec_ready   = dr;
   endtask

   // One cycle: inputs set at negedge, outputs sampled 1ns after posedge.
   task automatic cycle(input logic fl, input logic fv, input logic [31:0] pc, input logic dr);
      @(negedge clk);
      drive(fl, fv, pc, dr);
      @(posedge clk);
      #1;
   endtask

   initial begin
      drive(0, 0, 0, 0);

      // Fill to full with decode stalled, drop a 9th push, drain in order.
      for (int i = 0; i < 8; i++) add(0, 1, 32'(4*i), 0, i+1, i == 7, 1, 32'h0);
      add(0, 1, 32'h20, 0, 8, 1, 1, 32'h0);
      for (int k = 1; k <= 8; k++) add(0, 0, 0, 1, 8-k, 0, k < 8, (k < 8) ? 32'(4*k) : 32'h0);
      // Refill, then push+pop on full: pop wins, push rejected then retried.
      for (int i = 0; i < 8; i++) add(0, 1, 32'(32'h100 + 4*i), 0, i+1, i == 7, 1, 32'h100);
      add(0, 1, 32'h40, 1, 7, 0, 1, 32'h104);
      add(0, 1, 32'h40, 0, 8, 1, 1, 32'h104);

      // Reset state
      #2;
      chk("reset count", 64'(bus.count), 64'd0);
      chk("reset full", 64'(bus.I_FIFO_Full), 64'd0);
      chk("reset dec_valid", 64'(bus.dec_valid), 64'd0);
      chk("reset dec_pc", 64'(bus.dec_pc), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         cycle(tbl[i].fl, tbl[i].fv, tbl[i].pc, tbl[i].dr);
         chk($sformatf("vec%0d count", i), 64'(bus.count), 64'(tbl[i].cnt));
         chk($sformatf("vec%0d full", i), 64'(bus.I_FIFO_Full), 64'(tbl[i].full));
         chk($sformatf("vec%0d dec_valid", i), 64'(bus.dec_valid), 64'(tbl[i].dv));
         chk($sformatf("vec%0d dec_pc", i), 64'(bus.dec_pc), 64'(tbl[i].epc));
         chk($sformatf("vec%0d dec_instr", i), 64'(bus.dec_instr),
             64'(tbl[i].dv ? mk_instr(tbl[i].epc) : 32'h0));
      end

      // Flush from full
      cycle(1, 0, 0, 0);
      chk("flush full count", 64'(bus.count), 64'd0);
      chk("flush full I_FIFO_Full", 64'(bus.I_FIFO_Full), 64'd0);
      chk("flush full dec_valid", 64'(bus.dec_valid), 64'd0);

      // Wrap-around streaming: occupancy stays 1, PCs in order
      for (int j = 0; j < 20; j++) begin
         cycle(0, 1, 32'(32'h200 + 4*j), 1);
         chk($sformatf("stream%0d count", j), 64'(bus.count), 64'd1);
         chk($sformatf("stream%0d dec_pc", j), 64'(bus.dec_pc), 64'(32'h200 + 4*j));
      end
      cycle(0, 0, 0, 1);
      chk("stream drain count", 64'(bus.count), 64'd0);
      chk("stream drain dec_valid", 64'(bus.dec_valid), 64'd0);

      // Empty push latency: not visible before the edge, visible after
      @(negedge clk);
      drive(0, 1, 32'h300, 0);
      #2;
      chk("latency pre-edge dec_valid", 64'(bus.dec_valid), 64'd0);
      @(posedge clk);
      #1;
      chk("latency dec_valid", 64'(bus.dec_valid), 64'd1);
      chk("latency dec_instr", 64'(bus.dec_instr), 64'h0000_0013);

      // Flush priority with count=5
      for (int i = 1; i <= 4; i++) cycle(0, 1, 32'(32'h300 + 4*i), 0);
      chk("preflush count", 64'(bus.count), 64'd5);
      cycle(1, 1, 32'h999, 1);
      chk("flush count", 64'(bus.count), 64'd0);
      chk("flush dec_valid", 64'(bus.dec_valid), 64'd0);
      chk("flush dec_instr", 64'(bus.dec_instr), 64'd0);
      cycle(0, 0, 0, 0);
      chk("post-flush dec_valid", 64'(bus.dec_valid), 64'd0);
      chk("post-flush count", 64'(bus.count), 64'd0);

      // Async reset mid-stream with count=6
      for (int i = 0; i < 6; i++) cycle(0, 1, 32'(32'h400 + 4*i), 0);
      chk("prereset count", 64'(bus.count), 64'd6);
      @(negedge clk);
      drive(0, 0, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async reset count", 64'(bus.count), 64'd0);
      chk("async reset full", 64'(bus.I_FIFO_Full), 64'd0);
      chk("async reset dec_valid", 64'(bus.dec_valid), 64'd0);
      chk("async reset dec_pc", 64'(bus.dec_pc), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cycle(0, 1, 32'h500, 0);
      chk("post-reset count", 64'(bus.count), 64'd1);
      chk("post-reset dec_pc", 64'(bus.dec_pc), 64'h500);
      chk("post-reset dec_instr", 64'(bus.dec_instr), 64'(mk_instr(32'h500)));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/instr_fifo.md
# instr_fifo

Instruction queue between fetch and decode. Fetch pushes one instruction/PC pair per cycle; decode pops one per cycle from the head with a valid/ready handshake. The block produces `I_FIFO_Full`, which is one of the inputs to the fetch stall logic, and it clears its contents on a pipeline redirect.

## Interface

Parameters:

- `DEPTH`, 8: number of entries. Must be a power of 2 and ≥ 2.
- `INSTR_W`, 32: instruction width.
- `PC_W`, 32: PC width.

Ports:

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `fetch_valid`  in  1  fetch presents an instruction this cycle.
- `fetch_instr`  in  INSTR_W  instruction word.
- `fetch_pc`  in  PC_W  PC of `fetch_instr`.
- `flush`  in  1  redirect (mispredict or JALR resolve); empties the queue.
- `I_FIFO_Full`  out  1  queue holds DEPTH entries.
- `dec_valid`  out  1  head entry is valid.
- `dec_instr`  out  INSTR_W  head instruction.
- `dec_pc`  out  PC_W  head PC.
- `dec_ready`  in  1  decode accepts the head this cycle.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation

- Storage is a circular buffer of DEPTH entries, each holding {instr, pc}.
- `wr_ptr` and `rd_ptr` are each $clog2(DEPTH)+1 bits; the MSB is a wrap bit.
  - Empty: the pointers are equal.
  - Full: the low bits are equal and the MSBs differ.
  - Pointers wrap naturally modulo 2·DEPTH; there is no explicit compare-and-reset.
- Push is accepted iff `fetch_valid && !I_FIFO_Full && !flush`.
  - The entry is written at `wr_ptr[low]` and `wr_ptr` increments.
- Pop occurs iff `dec_valid && dec_ready && !flush`. `rd_ptr` increments.
- Full is decided from registered state only.
  - A push while full is rejected, even if a pop occurs in the same cycle.
  - No combinational path runs from `dec_ready` to push acceptance.
  - A rejected push is silently dropped. Fetch is responsible for stalling on `I_FIFO_Full`.
- Simultaneous push and pop (not full, not empty): both occur and `count` is unchanged.
- Push into an empty queue: there is no bypass. `dec_valid` rises on the cycle after the push edge.
- Flush has priority over push and pop in the same cycle.
  - Both pointers reset to 0 and `count` goes to 0 at the next edge.
  - A push or pop presented in the flush cycle is discarded.
  - Entry contents need not be cleared.
- Outputs:
  - `dec_valid` = !empty.
  - `dec_instr` and `dec_pc` are the head entry when `dec_valid`=1, and are forced to 0 when empty.
  - `count` = `wr_ptr − rd_ptr`, computed at full pointer width.
  - `I_FIFO_Full` = (`count` == DEPTH).
- Reset (`rst_n`=0) asserts asynchronously at any time, including mid-stream.
  - Pointers go to 0 immediately.
  - `I_FIFO_Full`=0, `dec_valid`=0, `dec_instr`=0, `dec_pc`=0, `count`=0.
  - Memory contents are don't-care.
  - Operation resumes on the first rising edge after `rst_n` deasserts.

## Timing

- Every output depends only on registered state. There is no input-to-output combinational path.
- Latency from push edge to the entry appearing at the decode head (when the queue was empty): 1 cycle.
- Throughput: one push and one pop per cycle sustained.
- `I_FIFO_Full` asserts in the cycle after the edge that writes the DEPTH-th entry. It deasserts in the cycle after the first pop from full.
- Decode may hold `dec_ready` low indefinitely. Head data is stable while `dec_valid`=1 and no pop or flush occurs.
- After `flush` is sampled, the following cycle shows `dec_valid`=0, `count`=0 and `I_FIFO_Full`=0.

## Test plan

- **Fill to full:** After reset, push 8 entries (pc 0x0,0x4,…,0x1C) with `dec_ready`=0.
  - `count`=8 and `I_FIFO_Full`=1 in cycle 9.
  - A 9th push (pc 0x20) is dropped.
  - Draining then yields pc 0x0..0x1C in order, and `dec_valid`=0 after the last pop.
- **Push/pop on full:** With the queue full, assert push (pc 0x40) and `dec_ready` together.
  - The pop occurs and the push is rejected: `count`=7, `I_FIFO_Full`=0.
  - Next cycle, the push of 0x40 is accepted and `count`=8.
- **Wrap-around:** Stream 20 entries with `fetch_valid`=1 and `dec_ready`=1 continuously.
  - `count` stays at 1 after the first cycle.
  - Decode sees all 20 PCs in order with no gaps, exercising pointer wrap twice.
- **Empty push latency:** From empty, push instr 0x00000013 at edge N.
  - `dec_valid`=1 with `dec_instr`=0x00000013 in cycle N+1, not in cycle N.
- **Flush priority:** With `count`=5, assert `flush` together with `fetch_valid` and `dec_ready`.
  - Next cycle: `count`=0, `dec_valid`=0, `dec_instr`=0.
  - The pushed entry never appears at the decode head.
- **Async reset mid-stream:** With `count`=6, pulse `rst_n` low between clock edges.
  - Outputs clear immediately: `count`=0, `I_FIFO_Full`=0, `dec_valid`=0.
  - A push after release appears at the head with `count`=1.
